// File: rtl/gate_self_test.sv
// Built-in self-test for Basic_gates: sweeps {A,B} over 00..11 and checks all seven gate outputs.
// Optional GATE_SELF_TEST_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module gate_self_test #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       and_ga,
  input  logic       or_ga,
  input  logic       not_ga,
  input  logic       nor_ga,
  input  logic       xor_ga,
  input  logic       xnor_ga,
  input  logic       nand_ga,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] fail_mask,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  typedef struct packed {
    logic [2:0] err_count;
    logic [6:0] fail_mask;
    logic [1:0] ff_vec;
    logic       ff_valid;
  } result_t;

  state_t          state, state_n;
  logic [1:0]      vec, vec_n;
  logic [CW-1:0]   cnt, cnt_n;
  result_t         res, res_n;
  logic            busy_n, done_n, pass_n;
  logic [6:0]      actual, expected, mismatch;
  logic            last_vec;

  always_comb begin
    actual   = {nand_ga, xnor_ga, xor_ga, nor_ga, not_ga, or_ga, and_ga};
    expected = {~(vec[1] & vec[0]), ~(vec[1] ^ vec[0]), vec[1] ^ vec[0],
                ~(vec[1] | vec[0]), ~vec[1], vec[1] | vec[0], vec[1] & vec[0]};
    mismatch = actual ^ expected;
  end

  always_comb begin
    state_n  = state;
    vec_n    = vec;
    cnt_n    = cnt;
    res_n    = res;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    last_vec = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          res_n   = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          vec_n   = 2'd0;
          busy_n  = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_n = SAMPLE;
        else           cnt_n   = cnt - 1'b1;
      end
      SAMPLE: begin
        res_n.fail_mask = res.fail_mask | mismatch;
        if (|mismatch) begin
          if (res.err_count < 3'd4) res_n.err_count = res.err_count + 3'd1;
          if (!res.ff_valid) begin
            res_n.ff_vec   = vec;
            res_n.ff_valid = 1'b1;
          end
        end
`ifdef GATE_SELF_TEST_STOP_ON_FAIL_EN
        last_vec = (vec == 2'd3) || (|mismatch);
`else
        last_vec = (vec == 2'd3);
`endif
        if (last_vec) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (res_n.err_count == 3'd0);
        end else begin
          // vec only advances here, so A/B hold steady for the whole vector period
          vec_n   = vec + 2'd1;
          cnt_n   = CNT_LOAD;
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= 2'd0;
      cnt   <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
      cnt   <= cnt_n;
      res   <= res_n;
      busy  <= busy_n;
      done  <= done_n;
      pass  <= pass_n;
    end
  end

  assign A                = vec[1];
  assign B                = vec[0];
  assign err_count        = res.err_count;
  assign fail_mask        = res.fail_mask;
  assign first_fail_vec   = res.ff_vec;
  assign first_fail_valid = res.ff_valid;
endmodule

// File: tb/tb_gate_self_test.sv
// Bench for gate_self_test: two instances (SETTLE_CYCLES 2 and 1) driving emulated gates with injectable stuck-at faults.
module tb_gate_self_test;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [6:0] s0, s1;

  logic       A_o [2], B_o [2], busy_o [2], done_o [2], pass_o [2], ffok_o [2];
  logic [2:0] err_o [2];
  logic [6:0] mask_o [2];
  logic [1:0] ffv_o [2];

  int checks = 0, failures = 0;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int S = (i == 0) ? 2 : 1;
    logic [6:0] gt;
    assign gt = ({~(A_o[i] & B_o[i]), ~(A_o[i] ^ B_o[i]), A_o[i] ^ B_o[i], ~(A_o[i] | B_o[i]),
                  ~A_o[i], A_o[i] | B_o[i], A_o[i] & B_o[i]} & ~s0) | s1;
    gate_self_test #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start),
      .and_ga(gt[0]), .or_ga(gt[1]), .not_ga(gt[2]), .nor_ga(gt[3]),
      .xor_ga(gt[4]), .xnor_ga(gt[5]), .nand_ga(gt[6]),
      .A(A_o[i]), .B(B_o[i]), .busy(busy_o[i]), .done(done_o[i]), .pass(pass_o[i]),
      .err_count(err_o[i]), .fail_mask(mask_o[i]),
      .first_fail_vec(ffv_o[i]), .first_fail_valid(ffok_o[i])
    );
  end

`ifdef GATE_SELF_TEST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // truth table of the seven gates from integer arithmetic on the vector index
  function automatic logic [6:0] truth(input int v);
    int a, b;
    logic [6:0] r;
    a = v / 2; b = v % 2;
    r[0] = (a * b == 1);
    r[1] = (a + b > 0);
    r[2] = (a == 0);
    r[3] = (a + b == 0);
    r[4] = (a + b == 1);
    r[5] = (a + b != 1);
    r[6] = (a * b == 0);
    return r;
  endfunction

  // reference model: time since run start, number of vectors already sampled
  bit         m_init = 1'b0;
  bit         m_run [2], m_fin [2];
  int         m_t [2], m_nd [2], m_total [2];
  logic [1:0] m_vec [2];
  logic [6:0] m_mis [2][4];

  task automatic model_step(input int i, input bit rs, input bit st);
    int p;
    p = ((i == 0) ? 2 : 1) + 1;
    if (rs) begin
      m_run[i] = 0; m_fin[i] = 0; m_t[i] = 0; m_nd[i] = 0; m_total[i] = 4; m_vec[i] = 2'd0;
      for (int v = 0; v < 4; v++) m_mis[i][v] = '0;
    end else if (st && !m_run[i]) begin
      m_run[i] = 1; m_fin[i] = 0; m_t[i] = 0; m_nd[i] = 0; m_vec[i] = 2'd0; m_total[i] = 4;
      for (int v = 0; v < 4; v++) m_mis[i][v] = ((truth(v) & ~s0) | s1) ^ truth(v);
      if (STOP) begin
        for (int v = 3; v >= 0; v--) if (m_mis[i][v] != 0) m_total[i] = v + 1;
      end
    end else if (m_run[i]) begin
      m_t[i]++;
      m_nd[i] = (m_t[i] / p < m_total[i]) ? m_t[i] / p : m_total[i];
      if (m_nd[i] == m_total[i]) begin
        m_run[i] = 0; m_fin[i] = 1; m_vec[i] = 2'(m_total[i] - 1);
      end else begin
        m_vec[i] = 2'(m_t[i] / p);
      end
    end
  endtask

  task automatic model_compare(input int i);
    int err, fv;
    logic [6:0] mask;
    bit fok;
    logic [17:0] exp_v, act_v;
    err = 0; mask = '0; fv = 0; fok = 0;
    for (int v = 0; v < m_nd[i]; v++) begin
      if (m_mis[i][v] != 0) begin
        err++;
        mask |= m_mis[i][v];
        if (!fok) begin fok = 1; fv = v; end
      end
    end
    exp_v = {m_vec[i], m_run[i], m_fin[i], m_fin[i] && (err == 0), 3'(err), mask, 2'(fv), fok};
    act_v = {A_o[i], B_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], mask_o[i], ffv_o[i], ffok_o[i]};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model[%0d] t=%0t {AB,busy,done,pass,err,mask,ffv,ffok} act=%b exp=%b",
               i, $time, act_v, exp_v);
    end
  endtask

  always begin
    bit rs, st;
    @(posedge clk);
    rs = rst; st = start;
    #1;
    if (rs) m_init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, rs, st);
      if (m_init) model_compare(i);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // returns at the negedge following the edge that samples start
  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!(done_o[0] && done_o[1]) && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_done timeout t=%0t", $time);
    end
  endtask

  initial begin
    int xor_done, n;
    bit did_rst;
    rst = 1'b1; start = 1'b0; s0 = '0; s1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy_o[0], 0);
    chk("rst_done", done_o[0], 0);
    chk("rst_err", err_o[0], 0);
    chk("rst_ab", {A_o[0], B_o[0]}, 0);

    // healthy gates: vector sequence and done timing for both settle lengths
    pulse_start();
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) chk("t1_vec", {A_o[0], B_o[0]}, k / 3);
      chk("t1_done0", done_o[0], (k >= 12) ? 1 : 0);
      chk("t1_done1", done_o[1], (k >= 8) ? 1 : 0);
      if (k < 12) @(negedge clk);
    end
    chk("t1_pass", pass_o[0], 1);
    chk("t1_err", err_o[0], 0);
    chk("t1_mask", mask_o[0], 0);
    chk("t1_pass1", pass_o[1], 1);

    // xor stuck at 0
    s0 = 7'b0010000;
    xor_done = STOP ? 6 : 12;
    pulse_start();
    for (int k = 0; k <= xor_done; k++) begin
      chk("t2_done", done_o[0], (k >= xor_done) ? 1 : 0);
      if (k < xor_done) @(negedge clk);
    end
    chk("t2_pass", pass_o[0], 0);
    chk("t2_err", err_o[0], STOP ? 1 : 2);
    chk("t2_mask", mask_o[0], 7'b0010000);
    chk("t2_ffv", ffv_o[0], 1);
    chk("t2_ffok", ffok_o[0], 1);
    wait_done();

    // start during a run is ignored, start in DONE restarts
    s0 = '0;
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("t3_done11", done_o[0], 0);
    @(negedge clk);
    chk("t3_done12", done_o[0], 1);
    chk("t3_pass", pass_o[0], 1);
    pulse_start();
    chk("t3_redone", done_o[0], 0);
    chk("t3_rebusy", busy_o[0], 1);
    chk("t3_reerr", err_o[0], 0);
    wait_done();
    chk("t3_repass", pass_o[0], 1);

    // reset mid-run at e0+7
    pulse_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t4_busy", busy_o[0], 0);
    chk("t4_done", done_o[0], 0);
    chk("t4_ab", {A_o[0], B_o[0]}, 0);
    chk("t4_busy1", busy_o[1], 0);
    s1 = 7'b0000100;
    pulse_start();
    wait_done();
    chk("t4_err", err_o[0], STOP ? 1 : 2);
    chk("t4_ffv", ffv_o[0], 2);
    chk("t4_mask", mask_o[0], 7'b0000100);

    // randomized faults, stray starts and resets
    for (int it = 0; it < 40; it++) begin
      s0 = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
      s1 = ($urandom_range(0, 2) == 0) ? 7'd0 : (7'($urandom) & ~s0);
      pulse_start();
      n = $urandom_range(0, 14);
      did_rst = 0;
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        if (j == n - 1 && $urandom_range(0, 4) == 0) begin
          rst = 1'b1; did_rst = 1;
        end
      end
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      if (!did_rst) wait_done();
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
